// File: rtl/aes_stream_loader.sv
// aes_stream_loader: collects a 32-byte frame (16 key bytes then 16 plaintext
// bytes, MSB first) from a byte stream, starts an AES core with a one-cycle
// load pulse, watches the core's busy flag with start and completion timeouts,
// and streams the 16-byte result back out MSB first.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_data_i/s_valid_i    inbound frame bytes; s_ready_o high only while receiving
//   load_o                one-cycle start pulse to the core
//   key_o/data_o          key and plaintext to the core, held until the next frame starts
//   core_data_i           core result, captured when core_busy_i falls
//   core_busy_i           core busy flag
//   m_data_o/m_valid_o    outbound result bytes, advanced on m_ready_i
//   error_o               one-cycle pulse when the core misses its start or completion window
module aes_stream_loader #(
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter int unsigned START_WINDOW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic         load_o,
  output logic [127:0] key_o,
  output logic [127:0] data_o,
  input  logic [127:0] core_data_i,
  input  logic         core_busy_i,
  output logic [7:0]   m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic         error_o
);

  localparam int unsigned TIMER_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [4:0]  RX_LAST = 5'd31;
  localparam logic [3:0]  TX_LAST = 4'd15;

  typedef enum logic [2:0] {RX, LOAD, START, RUN, TX} state_t;

  state_t               state_q, state_d;
  logic [4:0]           rx_cnt_q, rx_cnt_d;
  logic [3:0]           tx_cnt_q, tx_cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [255:0]         frame_q, frame_d;
  logic [127:0]         result_q, result_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 s_ready_q, s_ready_d;
  logic                 load_q, load_d;
  logic                 m_valid_q, m_valid_d;
  logic                 error_q, error_d;

  assign s_ready_o = s_ready_q;
  assign load_o    = load_q;
  assign key_o     = frame_q[255:128];
  assign data_o    = frame_q[127:0];
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign error_o   = error_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    rx_cnt_d  = rx_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    timer_d   = timer_q;
    frame_d   = frame_q;
    result_d  = result_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    error_d   = 1'b0;
    load_d    = 1'b0;
    s_ready_d = 1'b0;

    case (state_q)
      RX: begin
        if (s_valid_i && s_ready_q) begin
          // Shift left so byte 0 ends up in key_o[127:120]
          frame_d = {frame_q[247:0], s_data_i};
          if (rx_cnt_q == RX_LAST) begin
            rx_cnt_d = 5'd0;
            state_d  = LOAD;
          end else begin
            rx_cnt_d = rx_cnt_q + 5'd1;
          end
        end
      end
      LOAD: begin
        // timer holds the number of cycles elapsed since the load pulse
        timer_d = TIMER_W'(1);
        state_d = START;
      end
      START: begin
        if (core_busy_i) begin
          timer_d = timer_q + TIMER_W'(1);
          state_d = RUN;
        end else if (timer_q >= TIMER_W'(START_WINDOW - 1)) begin
          error_d = 1'b1;
          state_d = RX;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RUN: begin
        // Completion observed before the deadline wins over the timeout
        if (!core_busy_i) begin
          result_d  = core_data_i;
          m_data_d  = core_data_i[127:120];
          m_valid_d = 1'b1;
          tx_cnt_d  = 4'd0;
          state_d   = TX;
        end else if (timer_q >= TIMER_W'(BUSY_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = RX;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      TX: begin
        if (m_valid_q && m_ready_i) begin
          if (tx_cnt_q == TX_LAST) begin
            m_valid_d = 1'b0;
            state_d   = RX;
          end else begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            result_d = {result_q[119:0], 8'h00};
            m_data_d = result_q[119:112];
          end
        end
      end
      default: state_d = RX;
    endcase

    load_d    = (state_d == LOAD);
    s_ready_d = (state_d == RX);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RX;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      timer_q   <= '0;
      frame_q   <= '0;
      result_q  <= '0;
      m_data_q  <= '0;
      s_ready_q <= 1'b0;
      load_q    <= 1'b0;
      m_valid_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      timer_q   <= timer_d;
      frame_q   <= frame_d;
      result_q  <= result_d;
      m_data_q  <= m_data_d;
      s_ready_q <= s_ready_d;
      load_q    <= load_d;
      m_valid_q <= m_valid_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_aes_stream_loader.sv
// Testbench for aes_stream_loader: a behavioural core stub answers each load
// pulse; expected result bytes are queued when a frame is sent and popped as
// the loader streams them out.
module tb_aes_stream_loader;

  localparam logic [127:0] AES_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] MASK     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic         load_o;
  logic [127:0] key_o;
  logic [127:0] data_o;
  logic [127:0] core_data_i;
  logic         core_busy_i;
  logic [7:0]   m_data_o;
  logic         m_valid_o;
  logic         m_ready_i;
  logic         error_o;

  int n_chk  = 0;
  int n_fail = 0;
  int load_cnt = 0;
  int err_cnt  = 0;
  int mv_cnt   = 0;

  bit           never_busy = 1'b0;
  int           busy_len   = 10;
  bit           core_run   = 1'b0;
  int           core_timer = 0;
  logic [127:0] core_res   = '0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  aes_stream_loader #(.BUSY_TIMEOUT(64), .START_WINDOW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .load_o      (load_o),
    .key_o       (key_o),
    .data_o      (data_o),
    .core_data_i (core_data_i),
    .core_busy_i (core_busy_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .error_o     (error_o)
  );

  // Core stand-in: known AES answer for the all-zero frame, a reversible mix otherwise
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == '0 && d == '0) return AES_ZERO;
    return k ^ {d[63:0], d[127:64]} ^ MASK;
  endfunction

  // Busy rises the cycle after load_o and stays up for busy_len+1 cycles
  always @(posedge clk) begin
    if (load_o === 1'b1) begin
      core_run   <= 1'b1;
      core_timer <= 0;
      core_res   <= core_fn(key_o, data_o);
    end else if (core_run) begin
      core_timer <= core_timer + 1;
      if (core_timer == busy_len) core_run <= 1'b0;
    end
  end
  assign core_busy_i = core_run & ~never_busy;
  assign core_data_i = core_res;

  // Event counters
  always @(posedge clk) begin
    if (load_o === 1'b1)    load_cnt <= load_cnt + 1;
    if (error_o === 1'b1)   err_cnt  <= err_cnt + 1;
    if (m_valid_o === 1'b1) mv_cnt   <= mv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] r);
    for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready_o, 0);
    chk({tag, "_load"},    load_o,    0);
    chk({tag, "_m_valid"}, m_valid_o, 0);
    chk({tag, "_error"},   error_o,   0);
    chk({tag, "_m_data"},  m_data_o,  0);
    chk({tag, "_key"},     key_o,     0);
    chk({tag, "_data"},    data_o,    0);
  endtask

  // Send the first n bytes of f, MSB first, waiting (bounded) for s_ready_o
  task automatic send_frame(input logic [255:0] f, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      s_data_i  = f[255-8*i -: 8];
      s_valid_i = 1'b1;
      g = 0;
      while (s_ready_o !== 1'b1 && g < 200) begin
        tick();
        g++;
      end
      if (g >= 200) chk("ready_timeout", s_ready_o, 1);
      tick();
    end
    s_valid_i = 1'b0;
  endtask

  // Collect 16 result bytes against the queue; optional 1-0-1 ready toggling
  task automatic recv(input bit toggle, input bit sv_chk);
    int         got     = 0;
    int         g       = 0;
    logic [7:0] held    = '0;
    bit         stalled = 1'b0;
    while (got < 16 && g < 400) begin
      m_ready_i = toggle ? ~g[0] : 1'b1;
      if (sv_chk) chk("no_ready_busy", s_ready_o, 0);
      if (m_valid_o === 1'b1) begin
        if (stalled) chk("hold", m_data_o, held);
        if (m_ready_i) begin
          if (exp_q.size() > 0) chk("byte", m_data_o, exp_q.pop_front());
          else chk("extra_byte", m_valid_o, 0);
          got++;
          stalled = 1'b0;
        end else begin
          held    = m_data_o;
          stalled = 1'b1;
        end
      end
      tick();
      g++;
    end
    m_ready_i = 1'b0;
    chk("rx_count",      got,          16);
    chk("tx_done_valid", m_valid_o,    0);
    chk("tx_done_ready", s_ready_o,    1);
    chk("exp_empty",     exp_q.size(), 0);
  endtask

  initial begin
    logic [127:0] k, d;
    int lc, ec, mc, g;

    rst       = 1'b1;
    s_data_i  = '0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk("ready_after_rst", s_ready_o, 1);

    // All-zero frame: known AES answer, latency checks
    lc = load_cnt;
    push_exp(AES_ZERO);
    send_frame('0, 32);
    chk("A_load", load_o, 1);
    chk("A_key",  key_o,  0);
    chk("A_data", data_o, 0);
    tick();
    chk("A_load_pulse", load_o, 0);
    g = 0;
    while (core_busy_i !== 1'b1 && g < 20)  begin tick(); g++; end
    while (core_busy_i === 1'b1 && g < 200) begin tick(); g++; end
    chk("A_busy_done",   core_busy_i, 0);
    chk("A_mvalid_pre",  m_valid_o,   0);
    tick();
    chk("A_mvalid_lat",  m_valid_o,   1);
    recv(1'b0, 1'b0);
    chk("A_load_cnt", load_cnt - lc, 1);

    // Key 0, plaintext FF, downstream stalls every other cycle
    k = '0;
    d = '1;
    push_exp(core_fn(k, d));
    send_frame({k, d}, 32);
    chk("B_key",  key_o,  k);
    chk("B_data", data_o, d);
    recv(1'b1, 1'b0);

    // s_valid_i held through RUN/TX, then a following frame must arrive intact
    k = 128'h000102030405060708090a0b0c0d0e0f;
    d = 128'h101112131415161718191a1b1c1d1e1f;
    push_exp(core_fn(k, d));
    send_frame({k, d}, 32);
    s_valid_i = 1'b1;
    s_data_i  = 8'hee;
    recv(1'b0, 1'b1);
    s_valid_i = 1'b0;
    k = 128'hdeadbeef0123456789abcdeffedcba98;
    d = 128'h76543210a5a55a5a3c3cc3c396696996;
    push_exp(core_fn(k, d));
    send_frame({k, d}, 32);
    chk("C_key",  key_o,  k);
    chk("C_data", data_o, d);
    recv(1'b0, 1'b0);

    // Core never raises busy: error 4 cycles after load_o
    never_busy = 1'b1;
    ec = err_cnt;
    send_frame({k, d}, 32);
    chk("D_load", load_o, 1);
    repeat (3) tick();
    chk("D_err_early", error_o, 0);
    tick();
    chk("D_err", error_o, 1);
    tick();
    chk("D_err_pulse", error_o,   0);
    chk("D_ready",     s_ready_o, 1);
    chk("D_err_cnt",   err_cnt - ec, 1);
    repeat (12) tick();
    never_busy = 1'b0;

    // Core stays busy for ~100 cycles: error at 64 cycles, no output
    busy_len = 100;
    ec = err_cnt;
    mc = mv_cnt;
    send_frame({k, d}, 32);
    chk("E_load", load_o, 1);
    repeat (63) tick();
    chk("E_err_early", error_o, 0);
    tick();
    chk("E_err", error_o, 1);
    tick();
    chk("E_err_pulse", error_o, 0);
    repeat (50) tick();
    chk("E_no_mvalid", mv_cnt - mc, 0);
    chk("E_err_cnt",   err_cnt - ec, 1);
    chk("E_ready",     s_ready_o, 1);
    busy_len = 10;

    // Reset after 20 bytes, then a full F0 frame
    send_frame({32{8'h5a}}, 20);
    rst = 1'b1;
    #1;
    chk_reset("F_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("F_ready", s_ready_o, 1);
    lc = load_cnt;
    k = {16{8'hf0}};
    push_exp(core_fn(k, k));
    send_frame({k, k}, 32);
    chk("F_key",  key_o,  k);
    chk("F_data", data_o, k);
    recv(1'b0, 1'b0);
    chk("F_load_cnt", load_cnt - lc, 1);

    // Reset in the middle of TX, then a clean frame from byte 0
    send_frame({32{8'h3c}}, 32);
    m_ready_i = 1'b1;
    g = 0;
    while (m_valid_o !== 1'b1 && g < 200) begin tick(); g++; end
    chk("G_mvalid", m_valid_o, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    m_ready_i = 1'b0;
    chk("G_rst_mvalid", m_valid_o, 0);
    chk("G_rst_mdata",  m_data_o,  0);
    tick();
    rst = 1'b0;
    tick();
    k = 128'h0123456789abcdef0011223344556677;
    d = 128'h8899aabbccddeeff7766554433221100;
    push_exp(core_fn(k, d));
    send_frame({k, d}, 32);
    chk("G_key",  key_o,  k);
    chk("G_data", data_o, d);
    recv(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_stream_loader.md
AES_STREAM_LOADER -- requirements
Module: aes_stream_loader

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 64, giving the maximum cycles from load_o pulse to observed core completion.
REQ-002 SHALL have parameter START_WINDOW, default 4, giving the maximum cycles from load_o pulse to core_busy_i rising.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port s_data_i, input, 8 bits: inbound frame byte.
REQ-006 SHALL have port s_valid_i, input, 1 bit: s_data_i valid.
REQ-007 SHALL have port s_ready_o, output, 1 bit: loader accepts a byte.
REQ-008 SHALL have port load_o, output, 1 bit: one-cycle start pulse to the AES core.
REQ-009 SHALL have port key_o, output, 128 bits: key to the core.
REQ-010 SHALL have port data_o, output, 128 bits: plaintext to the core.
REQ-011 SHALL have port core_data_i, input, 128 bits: core result.
REQ-012 SHALL have port core_busy_i, input, 1 bit: core busy flag.
REQ-013 SHALL have port m_data_o, output, 8 bits: outbound result byte.
REQ-014 SHALL have port m_valid_o, output, 1 bit: m_data_o valid.
REQ-015 SHALL have port m_ready_i, input, 1 bit: downstream accepts a byte.
REQ-016 SHALL have port error_o, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-017 SHALL treat a frame as 32 bytes: bytes 0-15 form key_o, bytes 16-31 form data_o, MSB first (byte 0 -> key_o[127:120]).
REQ-018 SHALL transfer an input byte only in a cycle where s_valid_i and s_ready_o are both 1.
REQ-019 SHALL use the FSM states RX, LOAD, START, RUN, TX.
REQ-020 SHALL assert s_ready_o only in RX; in RX, a 5-bit byte counter increments per transfer.
REQ-021 SHALL, on the 32nd transfer (counter 31), move RX->LOAD and clear the counter.
REQ-022 SHALL, in LOAD, assert load_o for exactly one cycle with key_o/data_o stable, then move to START; key_o and data_o SHALL stay stable until the next frame's first byte is accepted.
REQ-023 SHALL, in START, move to RUN when core_busy_i=1; if busy is not seen within START_WINDOW cycles after load_o, it SHALL pulse error_o and return to RX.
REQ-024 SHALL, in RUN, capture core_data_i into a 128-bit result register in the first cycle core_busy_i=0, then move to TX.
REQ-025 SHALL, if the cycles since load_o reach BUSY_TIMEOUT before completion, pulse error_o for one cycle, discard the result, and return to RX.
REQ-026 SHALL, in TX, present result bytes MSB first with m_valid_o=1; a byte advances only on m_valid_o & m_ready_i, and m_data_o SHALL hold while m_ready_i=0.
REQ-027 SHALL, after the 16th TX handshake, deassert m_valid_o and return to RX in the next cycle.
REQ-028 SHALL ignore s_valid_i outside RX, with no bytes lost or buffered.
REQ-029 SHALL ignore core_busy_i outside START and RUN.
REQ-030 SHALL have a latency of exactly 1 cycle from the last input byte handshake to load_o=1.
REQ-031 SHALL produce the first m_valid_o=1 1 cycle after the RUN capture.

Reset
REQ-032 SHALL, while rst=1 (asynchronously), force state RX, counters 0, s_ready_o=0, load_o=0, m_valid_o=0, error_o=0, m_data_o=0, key_o=0, data_o=0, and result=0.
REQ-033 SHALL assert s_ready_o=1 in the first cycle after rst deasserts.
REQ-034 SHALL, on rst mid-frame or mid-TX, discard the partial frame or result; the next frame SHALL start at byte 0.

Verification
REQ-035 SHALL pass: 32 bytes of 0x00 into a real AES-128 core -> one load_o pulse, key_o=0, data_o=0, and output bytes 66 e9 4b d4 ef 8a 2c 3b 88 4c fa 59 ca 34 2b 2e.
REQ-036 SHALL pass: key 0 with plaintext FF x16, and m_ready_i toggled 1-0-1 each cycle -> 16 bytes, each held stable while stalled, with no duplicates or drops.
REQ-037 SHALL pass: a stub core that never raises busy -> error_o is a single pulse 4 cycles after load_o, then s_ready_o=1 in the next cycle.
REQ-038 SHALL pass: a stub core that holds busy for 100 cycles -> error_o pulses at 64 cycles after load_o and no m_valid_o is asserted.
REQ-039 SHALL pass: rst asserted after byte 20, then a full F0 x32 frame -> key_o and data_o both equal 0xF0F0...F0, with exactly one load_o pulse.
REQ-040 SHALL pass: s_valid_i held 1 during RUN/TX -> s_ready_o stays 0 and the following frame is received intact.
